// File: rtl/maxpool2d_2x2_stride2x2_if.sv
// Pixel stream bundle for the 2x2 max-pool stage: raster input and pooled output.
interface maxpool2d_2x2_stride2x2_if;
    logic [31:0] Data_In;
    logic        Valid_In;
    logic [31:0] Data_Out;
    logic        Valid_Out;

    // Upstream/consumer side: drives pixels, observes pooled results
    modport master (
        output Data_In,
        output Valid_In,
        input  Data_Out,
        input  Valid_Out
    );

    // Pooling block side
    modport slave (
        input  Data_In,
        input  Valid_In,
        output Data_Out,
        output Valid_Out
    );
endinterface

// File: rtl/maxpool2d_2x2_stride2x2.sv
// Streaming 2x2 / stride-2 max-pool on FP32 raster data, no backpressure.
// Compare uses the FP32 total order (sign-folded unsigned key), no FP arithmetic.
// Build option MAXPOOL_NAN_PROP_EN: any NaN in a window yields 32'h7FC00000.
module maxpool2d_2x2_stride2x2 #(
    parameter int unsigned IMG_WIDHT  = 149,
    parameter int unsigned IMG_HEIGHT = 149
) (
    input  logic                            clk,
    input  logic                            rst,
    maxpool2d_2x2_stride2x2_if.slave        bus
);
    localparam int unsigned OW = IMG_WIDHT / 2;
    localparam int unsigned CW = $clog2(IMG_WIDHT);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam int unsigned AW = (OW > 1) ? $clog2(OW) : 1;

    // Map FP32 bits onto an unsigned key whose order matches the FP total order
    function automatic logic [31:0] order_key(input logic [31:0] b);
        return b[31] ? ~b : (b ^ 32'h8000_0000);
    endfunction

    // Larger key wins; on a tie the earlier operand a is kept
    function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
        return (order_key(b) > order_key(a)) ? b : a;
    endfunction

`ifdef MAXPOOL_NAN_PROP_EN
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    logic           pair_nan_q, pair_nan_d;
    logic           h_nan;
    logic           row_nan [OW];
`endif

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [31:0]    pair_q, pair_d;
    logic [31:0]    dout_q, dout_d;
    logic           vout_q, vout_d;

    logic [31:0]    row_buf [OW];
    logic           buf_we;
    logic [AW-1:0]  buf_addr;
    logic [31:0]    h_max;
    logic           col_last;
    logic           row_last;

    assign col_last = (col_q == CW'(IMG_WIDHT - 1));
    assign row_last = (row_q == RW'(IMG_HEIGHT - 1));
    assign buf_addr = AW'(col_q >> 1);
    assign h_max    = fp_max(pair_q, bus.Data_In);
`ifdef MAXPOOL_NAN_PROP_EN
    assign h_nan    = pair_nan_q | is_nan(bus.Data_In);
`endif

    // Next-state: raster counters, pair latch, row-buffer write and pooled output.
    // A trailing odd column/row only ever latches the pair register or writes the
    // row buffer, both of which are overwritten before being read, so it emits nothing.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        pair_d = pair_q;
        dout_d = dout_q;
        vout_d = 1'b0;
        buf_we = 1'b0;
`ifdef MAXPOOL_NAN_PROP_EN
        pair_nan_d = pair_nan_q;
`endif
        if (bus.Valid_In) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                pair_d = bus.Data_In;
`ifdef MAXPOOL_NAN_PROP_EN
                pair_nan_d = is_nan(bus.Data_In);
`endif
            end else if (!row_q[0]) begin
                buf_we = 1'b1;
            end else begin
                dout_d = fp_max(row_buf[buf_addr], h_max);
                vout_d = 1'b1;
`ifdef MAXPOOL_NAN_PROP_EN
                if (row_nan[buf_addr] | h_nan) begin
                    dout_d = QNAN;
                end
`endif
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            pair_q <= '0;
            dout_q <= '0;
            vout_q <= 1'b0;
`ifdef MAXPOOL_NAN_PROP_EN
            pair_nan_q <= 1'b0;
`endif
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            pair_q <= pair_d;
            dout_q <= dout_d;
            vout_q <= vout_d;
`ifdef MAXPOOL_NAN_PROP_EN
            pair_nan_q <= pair_nan_d;
`endif
        end
    end

    // Row buffer of even-row horizontal maxima; contents need no reset
    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf[buf_addr] <= h_max;
`ifdef MAXPOOL_NAN_PROP_EN
            row_nan[buf_addr] <= h_nan;
`endif
        end
    end

    assign bus.Data_Out  = dout_q;
    assign bus.Valid_Out = vout_q;
endmodule

// File: tb/tb_maxpool2d_2x2_stride2x2.sv
// Self-checking bench for maxpool2d_2x2_stride2x2: a 4x4 and a 5x5 instance,
// directed frame tables, gapped/reset sequences and random frames against a
// frame-array reference model. Honours MAXPOOL_NAN_PROP_EN like the design.
module tb_maxpool2d_2x2_stride2x2;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    maxpool2d_2x2_stride2x2_if if4();
    maxpool2d_2x2_stride2x2_if if5();

    maxpool2d_2x2_stride2x2 #(.IMG_WIDHT(4), .IMG_HEIGHT(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    maxpool2d_2x2_stride2x2 #(.IMG_WIDHT(5), .IMG_HEIGHT(5)) u5 (
        .clk (clk),
        .rst (rst),
        .bus (if5.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: per instance frame image, raster position, last output
    logic [31:0] fr [2][5][5];
    int          mr [2];
    int          mc [2];
    logic [31:0] last_out [2];
    logic [31:0] got [$];

    typedef struct {
        int                sel;
        int                npx;
        logic [0:24][31:0] px;
        int                nexp;
        logic [0:3][31:0]  exp;
    } vec_t;

    vec_t        tbl [3];
    logic [31:0] specials [10];

    function automatic int dim_of(input int s);
        return (s == 0) ? 4 : 5;
    endfunction

    function automatic logic [31:0] order_key(input logic [31:0] b);
        return b[31] ? ~b : (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        return (order_key(b) > order_key(a)) ? b : a;
    endfunction

    function automatic bit nan_bits(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    // Max over the 2x2 window with top-left (r0,c0), raster order reduction
    function automatic logic [31:0] win_max(input int s, input int r0, input int c0);
        logic [31:0] m;
        bit          any_nan;
        m = fr[s][r0][c0];
        any_nan = 1'b0;
        for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
                m = fmax(m, fr[s][r0+dr][c0+dc]);
                if (nan_bits(fr[s][r0+dr][c0+dc])) any_nan = 1'b1;
            end
        end
`ifdef MAXPOOL_NAN_PROP_EN
        if (any_nan) m = 32'h7FC0_0000;
`endif
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock with optional pixel on instance s; checks Valid_Out/Data_Out after the edge
    task automatic step(input int s, input bit v, input logic [31:0] d);
        logic        ev;
        logic [31:0] ed;
        logic        av;
        logic [31:0] ad;
        int          w;
        int          h;
        w = dim_of(s);
        h = dim_of(s);
        if (s == 0) begin
            if4.Valid_In = v; if4.Data_In = d; if5.Valid_In = 1'b0;
        end else begin
            if5.Valid_In = v; if5.Data_In = d; if4.Valid_In = 1'b0;
        end
        @(posedge clk);
        #1;
        ev = 1'b0;
        ed = last_out[s];
        if (v) begin
            fr[s][mr[s]][mc[s]] = d;
            if ((mr[s] % 2 == 1) && (mc[s] % 2 == 1) &&
                (mr[s] < 2 * (h / 2)) && (mc[s] < 2 * (w / 2))) begin
                ev = 1'b1;
                ed = win_max(s, mr[s] - 1, mc[s] - 1);
            end
            if (mc[s] == w - 1) begin
                mc[s] = 0;
                mr[s] = (mr[s] == h - 1) ? 0 : mr[s] + 1;
            end else begin
                mc[s] = mc[s] + 1;
            end
        end
        av = (s == 0) ? if4.Valid_Out : if5.Valid_Out;
        ad = (s == 0) ? if4.Data_Out  : if5.Data_Out;
        check("valid_out", 32'(av), 32'(ev));
        check("data_out", ad, ed);
        if (av === 1'b1) got.push_back(ad);
        last_out[s] = ed;
        if4.Valid_In = 1'b0;
        if5.Valid_In = 1'b0;
    endtask

    // Async reset with Valid_In held high while rst is high (must be ignored)
    task automatic do_reset();
        rst = 1'b1;
        if4.Valid_In = 1'b1; if4.Data_In = 32'h4B00_0000;
        if5.Valid_In = 1'b1; if5.Data_In = 32'h4B00_0000;
        #1;
        check("rst_valid4", 32'(if4.Valid_Out), 32'd0);
        check("rst_data4",  if4.Data_Out, 32'd0);
        check("rst_valid5", 32'(if5.Valid_Out), 32'd0);
        check("rst_data5",  if5.Data_Out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid4", 32'(if4.Valid_Out), 32'd0);
        check("rst_hold_data5",  if5.Data_Out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        if4.Valid_In = 1'b0;
        if5.Valid_In = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mr[s] = 0; mc[s] = 0; last_out[s] = 32'd0;
        end
        got.delete();
    endtask

    task automatic check_got(input string name, input int t);
        check({name, "_count"}, 32'(got.size()), 32'(tbl[t].nexp));
        for (int k = 0; k < tbl[t].nexp; k++) begin
            if (k < got.size()) check({name, "_value"}, got[k], tbl[t].exp[k]);
            else                check({name, "_missing"}, 32'hDEAD_DEAD, tbl[t].exp[k]);
        end
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0, 1, 2: return $urandom();
            3, 4:    return specials[$urandom_range(0, 9)];
            5:       return {1'b1, 8'($urandom_range(120, 135)), 23'($urandom())};
            default: return {1'b0, 8'($urandom_range(120, 135)), 23'($urandom())};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if4.Valid_In = 1'b0; if4.Data_In = 32'd0;
        if5.Valid_In = 1'b0; if5.Data_In = 32'd0;

        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'hFFC0_0001, 32'h0000_0001, 32'h8000_0001,
                     32'h3F80_0000, 32'hBF80_0000};

        // 4x4 ramp 1.0..16.0
        tbl[0].sel  = 0;
        tbl[0].npx  = 16;
        tbl[0].px   = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                       32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                       32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                       32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000,
                       32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[0].nexp = 4;
        tbl[0].exp  = {32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

        // 5x5 with negatives and a trailing column/row of 100.0
        tbl[1].sel  = 1;
        tbl[1].npx  = 25;
        tbl[1].px   = {32'hC0400000, 32'hBF800000, 32'h3F800000, 32'h40000000, 32'h42C80000,
                       32'hC0000000, 32'h80000000, 32'h40400000, 32'h40800000, 32'h42C80000,
                       32'h40A00000, 32'h40C00000, 32'hBF800000, 32'hC0000000, 32'h42C80000,
                       32'h40E00000, 32'h3F800000, 32'hC0400000, 32'h80000000, 32'h42C80000,
                       32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000};
        tbl[1].nexp = 4;
        tbl[1].exp  = {32'h80000000, 32'h40800000, 32'h40E00000, 32'h80000000};

        // 4x4 signed zeros, NaNs, infinities, denormals
        tbl[2].sel  = 0;
        tbl[2].npx  = 16;
        tbl[2].px   = {32'h80000000, 32'h00000000, 32'h7FC00001, 32'h40A00000,
                       32'h80000000, 32'h80000000, 32'h40A00000, 32'h40A00000,
                       32'h7F800000, 32'hFF800000, 32'h00000001, 32'h00000002,
                       32'hFFC00000, 32'h3F800000, 32'h80000001, 32'h00000000,
                       32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[2].nexp = 4;
`ifdef MAXPOOL_NAN_PROP_EN
        tbl[2].exp  = {32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h00000002};
`else
        tbl[2].exp  = {32'h00000000, 32'h7FC00001, 32'h7F800000, 32'h00000002};
`endif

        // Directed tables, continuous Valid_In
        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int i = 0; i < tbl[t].npx; i++) step(tbl[t].sel, 1'b1, tbl[t].px[i]);
            check_got($sformatf("table%0d", t), t);
        end

        // Ramp with random idle gaps of 0..5 cycles
        do_reset();
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = $urandom_range(0, 5);
            for (int g = 0; g < gaps; g++) step(0, 1'b0, $urandom());
            step(0, 1'b1, tbl[0].px[i]);
        end
        for (int g = 0; g < 3; g++) step(0, 1'b0, $urandom());
        check_got("gapped", 0);

        // Reset mid-frame after 6 pixels, then a fresh frame
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 1'b1, tbl[2].px[i]);
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 1'b1, tbl[0].px[i]);
        check_got("after_reset", 0);

        // Random back-to-back frames on both geometries
        do_reset();
        for (int f = 0; f < 12; f++) begin
            int s;
            s = f % 2;
            for (int i = 0; i < dim_of(s) * dim_of(s); i++) begin
                int gaps;
                gaps = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                for (int g = 0; g < gaps; g++) step(s, 1'b0, $urandom());
                step(s, 1'b1, rand_val());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
